// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux source sequencer: FSM states, sizes and
// the valid-index search used when empty sources are skipped.
package mux_seq_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} seq_state_t;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 3;
    localparam int PASS_W  = 4;

    // Returns {wrapped, index} of the first valid source after cur, searching upward
    // and wrapping past the last source; wrapped=1 means the sweep crossed index 3.
    function automatic logic [2:0] next_valid_idx(input logic [NUM_SRC-1:0] valid,
                                                  input logic [1:0]         cur);
        logic [2:0] res;
        logic [2:0] j;
        logic       found;
        res   = {1'b1, cur};
        found = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            j = {1'b0, cur} + 3'(i);
            if (!found && valid[j[1:0]]) begin
                res   = j;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_src_regfile.sv
// Four W-bit source registers with per-entry valid bits; clear and reset empty
// every entry, a write loads one entry and marks it valid.
module mux_src_regfile
    import mux_seq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [1:0]         wr_addr_i,
    input  logic [W-1:0]       wr_data_i,
    output logic [W-1:0]       src_o [NUM_SRC],
    output logic [NUM_SRC-1:0] valid_o
);

    logic [W-1:0]       src_q [NUM_SRC];
    logic [W-1:0]       src_d [NUM_SRC];
    logic [NUM_SRC-1:0] valid_q;
    logic [NUM_SRC-1:0] valid_d;

    always_comb begin
        src_d   = src_q;
        valid_d = valid_q;
        if (clr_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_d[i] = '0;
            end
            valid_d = '0;
        end else if (wr_en_i) begin
            src_d[wr_addr_i]   = wr_data_i;
            valid_d[wr_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign src_o   = src_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mux_src_sequencer.sv
// Source registers plus select sequencer feeding the downstream 4:1 registered mux.
// Define SEL_SKIP_EMPTY_EN to make sweeps visit only sources that have been written.
module mux_src_sequencer
    import mux_seq_pkg::*;
#(
    parameter int W      = 1,
    parameter int PASSES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             start,
    input  logic             hold,
    output logic [SEL_W-1:0] state,
    output logic [W-1:0]     R0,
    output logic [W-1:0]     R1,
    output logic [W-1:0]     R2,
    output logic [W-1:0]     R3,
    output logic             busy,
    output logic             done,
    output logic             wr_err
);

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    seq_state_t         fsm_q, fsm_d;
    logic [1:0]         sel_q, sel_d;
    logic [PASS_W-1:0]  pass_q, pass_d;
    logic               wr_err_q, wr_err_d;
    logic [W-1:0]       src [NUM_SRC];
    logic [NUM_SRC-1:0] valid;
    logic [1:0]         first_sel;
    logic               start_empty;
    logic [2:0]         next_idx;

    mux_src_regfile #(.W(W)) u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (clr),
        .wr_en_i   (wr_en && (fsm_q != SCAN)),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .src_o     (src),
        .valid_o   (valid)
    );

`ifdef SEL_SKIP_EMPTY_EN
    logic [NUM_SRC-1:0] valid_at_start;
    logic               first_unused;

    // A write in the start cycle counts as valid so the new source is swept.
    always_comb begin
        valid_at_start = valid;
        if (wr_en) begin
            valid_at_start[wr_addr] = 1'b1;
        end
    end

    assign {first_unused, first_sel} = next_valid_idx(valid_at_start, 2'd3);
    assign start_empty               = (valid_at_start == '0);
    assign next_idx                  = next_valid_idx(valid, sel_q);
`else
    logic valid_unused;

    assign first_sel    = 2'd0;
    assign start_empty  = 1'b0;
    assign next_idx     = {sel_q == 2'd3, sel_q + 2'd1};
    assign valid_unused = ^valid;
`endif

    // next_idx[2] marks the end of a pass; the last pass ends the sweep.
    always_comb begin
        fsm_d    = fsm_q;
        sel_d    = sel_q;
        pass_d   = pass_q;
        wr_err_d = wr_en && (fsm_q == SCAN);
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    pass_d = '0;
                    if (start_empty) begin
                        fsm_d = DONE;
                        sel_d = 2'd0;
                    end else begin
                        fsm_d = SCAN;
                        sel_d = first_sel;
                    end
                end
            end
            SCAN: begin
                if (!hold) begin
                    sel_d = next_idx[1:0];
                    if (next_idx[2]) begin
                        pass_d = pass_q + PASS_W'(1);
                        if (pass_q == LAST_PASS) begin
                            fsm_d = DONE;
                            sel_d = 2'd0;
                        end
                    end
                end
            end
            DONE: begin
                fsm_d = IDLE;
                sel_d = 2'd0;
            end
            default: begin
                fsm_d = IDLE;
                sel_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fsm_q    <= IDLE;
            sel_q    <= 2'd0;
            pass_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            sel_q    <= sel_d;
            pass_q   <= pass_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign state  = {{(SEL_W-2){1'b0}}, sel_q};
    assign R0     = src[0];
    assign R1     = src[1];
    assign R2     = src[2];
    assign R3     = src[3];
    assign busy   = (fsm_q == SCAN);
    assign done   = (fsm_q == DONE);
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_mux_src_sequencer.sv
// Bench for mux_src_sequencer: two instances (PASSES=1 and PASSES=2) checked against
// a sweep-list reference model plus directed scenario checks.
module tb_mux_src_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic       wr_data = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;

    logic [2:0] stO   [2];
    logic       rO    [2][4];
    logic       busyO [2];
    logic       doneO [2];
    logic       werrO [2];
    logic       r4    [2];

    int vectors = 0;
    int miscompares = 0;

`ifdef SEL_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    always #5 clk = ~clk;

    mux_src_sequencer #(.W(1), .PASSES(1)) u_p1 (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .hold(hold), .state(stO[0]),
        .R0(rO[0][0]), .R1(rO[0][1]), .R2(rO[0][2]), .R3(rO[0][3]),
        .busy(busyO[0]), .done(doneO[0]), .wr_err(werrO[0])
    );

    mux_src_sequencer #(.W(1), .PASSES(2)) u_p2 (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .hold(hold), .state(stO[1]),
        .R0(rO[1][0]), .R1(rO[1][1]), .R2(rO[1][2]), .R3(rO[1][3]),
        .busy(busyO[1]), .done(doneO[1]), .wr_err(werrO[1])
    );

    // Downstream registered mux, fed from the DUT outputs.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            r4[k] <= rst ? 1'b0 : rO[k][stO[k][1:0]];
        end
    end

    // Reference model: a start builds the full list of indices to visit; each
    // unheld cycle consumes one entry and an emptied list produces the done pulse.
    int   passesOf [2] = '{1, 2};
    logic mSrc   [2][4];
    logic mValid [2][4];
    int   mSeq   [2][16];
    int   mHead  [2];
    int   mLen   [2];
    logic mDone  [2];
    logic mWerr  [2];
    logic mR4    [2];
    int   mCur;
    bit   mWasBusy;
    bit   mNextDone;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mWasBusy  = mLen[k] > mHead[k];
            mCur      = mWasBusy ? mSeq[k][mHead[k]] : 0;
            mNextDone = 1'b0;
            mR4[k]    = rst ? 1'b0 : mSrc[k][mCur];
            if (rst || clr) begin
                for (int i = 0; i < 4; i++) begin
                    mSrc[k][i]   = 1'b0;
                    mValid[k][i] = 1'b0;
                end
                mHead[k] = 0;
                mLen[k]  = 0;
                mDone[k] = 1'b0;
                mWerr[k] = 1'b0;
            end else begin
                mWerr[k] = wr_en && mWasBusy;
                if (wr_en && !mWasBusy) begin
                    mSrc[k][wr_addr]   = wr_data;
                    mValid[k][wr_addr] = 1'b1;
                end
                if (mWasBusy) begin
                    if (!hold) begin
                        mHead[k]++;
                        mNextDone = (mHead[k] == mLen[k]);
                    end
                end else if (start && !mDone[k]) begin
                    mHead[k] = 0;
                    mLen[k]  = 0;
                    for (int p = 0; p < passesOf[k]; p++) begin
                        for (int i = 0; i < 4; i++) begin
                            if (!SKIP || mValid[k][i]) begin
                                mSeq[k][mLen[k]] = i;
                                mLen[k]++;
                            end
                        end
                    end
                    mNextDone = (mLen[k] == 0);
                end
                mDone[k] = mNextDone;
            end
        end
    end

    function automatic logic [21:0] modelVec();
        logic [10:0] e [2];
        logic [2:0]  st;
        for (int k = 0; k < 2; k++) begin
            st   = (mLen[k] > mHead[k]) ? 3'(mSeq[k][mHead[k]]) : 3'd0;
            e[k] = {st, mSrc[k][3], mSrc[k][2], mSrc[k][1], mSrc[k][0],
                    mLen[k] > mHead[k], mDone[k], mWerr[k], mR4[k]};
        end
        return {e[1], e[0]};
    endfunction

    function automatic logic [21:0] dutVec();
        logic [10:0] e [2];
        for (int k = 0; k < 2; k++) begin
            e[k] = {stO[k], rO[k][3], rO[k][2], rO[k][1], rO[k][0],
                    busyO[k], doneO[k], werrO[k], r4[k]};
        end
        return {e[1], e[0]};
    endfunction

    task automatic applyStimulus(input logic r, input logic c, input logic we,
                                 input logic [1:0] a, input logic d,
                                 input logic st, input logic h);
        rst = r; clr = c; wr_en = we; wr_addr = a; wr_data = d; start = st; hold = h;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] d;
        d = 4'b1101;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (stO[0] !== 3'd0 || busyO[0] !== 1'b0 || doneO[0] !== 1'b0 || werrO[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got state=%0d busy=%b done=%b wr_err=%b, want 0 0 0 0",
                     stO[0], busyO[0], doneO[0], werrO[0]);
        end
        for (int a = 0; a < 4; a++) applyStimulus(0, 0, 1, 2'(a), d[a], 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (stO[0] !== 3'd2 || busyO[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_scan: got state=%0d busy=%b, want state=2 busy=1", stO[0], busyO[0]);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (stO[k] !== 3'd0 || busyO[k] !== 1'b0 || doneO[k] !== 1'b0 ||
                {rO[k][3], rO[k][2], rO[k][1], rO[k][0]} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL reset_midscan inst%0d: got state=%0d busy=%b done=%b R=%b%b%b%b, want 0 0 0 0000",
                         k, stO[k], busyO[k], doneO[k], rO[k][3], rO[k][2], rO[k][1], rO[k][0]);
            end
        end
        vectors++;
        if (dutVec() !== modelVec()) begin
            miscompares++;
            $display("[TB] FAIL reset_model: dut=%h model=%h", dutVec(), modelVec());
        end
    endtask

    task automatic test_sweep();
        logic [3:0] d;
        logic       expBusy;
        logic       expDone;
        int         expSt;
        d = 4'b1101;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) applyStimulus(0, 0, 1, 2'(a), d[a], 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 6; c++) begin
            vectors++;
            if (dutVec() !== modelVec()) begin
                miscompares++;
                $display("[TB] FAIL sweep_model c%0d: dut=%h model=%h", c, dutVec(), modelVec());
            end
            expSt   = (c <= 4) ? c - 1 : 0;
            expBusy = (c <= 4);
            expDone = (c == 5);
            vectors++;
            if (stO[0] !== 3'(expSt) || busyO[0] !== expBusy || doneO[0] !== expDone) begin
                miscompares++;
                $display("[TB] FAIL sweep_seq c%0d: got state=%0d busy=%b done=%b, want %0d %b %b",
                         c, stO[0], busyO[0], doneO[0], expSt, expBusy, expDone);
            end
            if (c >= 2 && c <= 5) begin
                vectors++;
                if (r4[0] !== d[c-2]) begin
                    miscompares++;
                    $display("[TB] FAIL sweep_r4 c%0d: got %b, want %b", c, r4[0], d[c-2]);
                end
            end
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_hold();
        int expSt [10] = '{0, 1, 1, 1, 2, 3, 0, 1, 2, 3};
        int doneCount;
        doneCount = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) applyStimulus(0, 0, 1, 2'(a), 1'($urandom_range(0, 1)), 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 12; c++) begin
            vectors++;
            if (dutVec() !== modelVec()) begin
                miscompares++;
                $display("[TB] FAIL hold_model c%0d: dut=%h model=%h", c, dutVec(), modelVec());
            end
            vectors++;
            if (c <= 10) begin
                if (stO[1] !== 3'(expSt[c-1]) || busyO[1] !== 1'b1 || doneO[1] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL hold_seq c%0d: got state=%0d busy=%b done=%b, want %0d 1 0",
                             c, stO[1], busyO[1], doneO[1], expSt[c-1]);
                end
            end else if (stO[1] !== 3'd0 || busyO[1] !== 1'b0 || doneO[1] !== (c == 11)) begin
                miscompares++;
                $display("[TB] FAIL hold_end c%0d: got state=%0d busy=%b done=%b, want 0 0 %b",
                         c, stO[1], busyO[1], doneO[1], c == 11);
            end
            doneCount += int'(doneO[1]);
            applyStimulus(0, 0, 0, 0, 0, 0, (c == 2 || c == 3));
        end
        vectors++;
        if (doneCount !== 1) begin
            miscompares++;
            $display("[TB] FAIL hold_done_count: got %0d pulses, want 1", doneCount);
        end
    endtask

    task automatic test_write_err();
        int n;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 2, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (werrO[k] !== 1'b1 || rO[k][2] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL wr_err_pulse inst%0d: got wr_err=%b R2=%b, want 1 0", k, werrO[k], rO[k][2]);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (werrO[0] !== 1'b0 || werrO[1] !== 1'b0 || dutVec() !== modelVec()) begin
            miscompares++;
            $display("[TB] FAIL wr_err_clear: got wr_err=%b%b dut=%h, want 00 model=%h",
                     werrO[1], werrO[0], dutVec(), modelVec());
        end
        n = 0;
        while ((busyO[0] || busyO[1] || doneO[0] || doneO[1]) && n < 20) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            n++;
            vectors++;
            if (dutVec() !== modelVec()) begin
                miscompares++;
                $display("[TB] FAIL wr_wait_model: dut=%h model=%h", dutVec(), modelVec());
            end
        end
        vectors++;
        if (busyO[0] || busyO[1] || doneO[0] || doneO[1]) begin
            miscompares++;
            $display("[TB] FAIL wait_idle: got busy=%b%b done=%b%b after 20 cycles, want idle",
                     busyO[1], busyO[0], doneO[1], doneO[0]);
        end
        applyStimulus(0, 0, 1, 2, 1, 1, 0);
        vectors++;
        if (rO[0][2] !== 1'b1 || rO[1][2] !== 1'b1 || busyO[0] !== 1'b1 || stO[0] !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL write_start: got R2=%b%b busy=%b state=%0d, want 11 1 0",
                     rO[1][2], rO[0][2], busyO[0], stO[0]);
        end
        n = 0;
        while (stO[0] !== 3'd2 && n < 6) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        vectors++;
        if (stO[0] !== 3'd2 || rO[0][2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL write_start_visible: got state=%0d R2=%b, want 2 1", stO[0], rO[0][2]);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (r4[0] !== 1'b1 || dutVec() !== modelVec()) begin
            miscompares++;
            $display("[TB] FAIL write_start_r4: got r4=%b dut=%h, want 1 model=%h", r4[0], dutVec(), modelVec());
        end
    endtask

    task automatic test_clear();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) applyStimulus(0, 0, 1, 2'(a), 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (stO[0] !== 3'd3) begin
            miscompares++;
            $display("[TB] FAIL pre_clr_state: got %0d, want 3", stO[0]);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (stO[k] !== 3'd0 || busyO[k] !== 1'b0 || doneO[k] !== 1'b0 ||
                {rO[k][3], rO[k][2], rO[k][1], rO[k][0]} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL clr_state inst%0d: got state=%0d busy=%b done=%b R=%b%b%b%b, want 0 0 0 0000",
                         k, stO[k], busyO[k], doneO[k], rO[k][3], rO[k][2], rO[k][1], rO[k][0]);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (doneO[0] !== 1'b0 || doneO[1] !== 1'b0 || dutVec() !== modelVec()) begin
            miscompares++;
            $display("[TB] FAIL clr_no_done: got done=%b%b dut=%h, want 00 model=%h",
                     doneO[1], doneO[0], dutVec(), modelVec());
        end
        applyStimulus(0, 0, 1, 0, 1, 1, 0);
        vectors++;
        if (busyO[0] !== 1'b1 || busyO[1] !== 1'b1 || stO[0] !== 3'd0 || dutVec() !== modelVec()) begin
            miscompares++;
            $display("[TB] FAIL clr_restart: got busy=%b%b state=%0d dut=%h, want 11 0 model=%h",
                     busyO[1], busyO[0], stO[0], dutVec(), modelVec());
        end
    endtask

`ifdef SEL_SKIP_EMPTY_EN
    task automatic test_skip();
        int exp1 [2] = '{1, 3};
        int exp2 [4] = '{1, 3, 1, 3};
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 3, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 6; c++) begin
            vectors++;
            if ((c <= 2 && (stO[0] !== 3'(exp1[c-1]) || busyO[0] !== 1'b1)) ||
                (c > 2 && (busyO[0] !== 1'b0 || doneO[0] !== (c == 3))) ||
                (c <= 4 && (stO[1] !== 3'(exp2[c-1]) || busyO[1] !== 1'b1)) ||
                (c > 4 && (busyO[1] !== 1'b0 || doneO[1] !== (c == 5)))) begin
                miscompares++;
                $display("[TB] FAIL skip_seq c%0d: got state=%0d/%0d busy=%b%b done=%b%b",
                         c, stO[0], stO[1], busyO[1], busyO[0], doneO[1], doneO[0]);
            end
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        vectors++;
        if (doneO[0] !== 1'b1 || doneO[1] !== 1'b1 || busyO[0] !== 1'b0 || busyO[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL skip_empty: got done=%b%b busy=%b%b, want 11 00",
                     doneO[1], doneO[0], busyO[1], busyO[0]);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (doneO[0] !== 1'b0 || busyO[0] !== 1'b0 || dutVec() !== modelVec()) begin
            miscompares++;
            $display("[TB] FAIL skip_empty_end: got done=%b busy=%b dut=%h model=%h",
                     doneO[0], busyO[0], dutVec(), modelVec());
        end
    endtask
`endif

    task automatic test_random();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
                          $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                          $urandom_range(0, 3) == 0);
            vectors++;
            if (dutVec() !== modelVec()) begin
                miscompares++;
                $display("[TB] FAIL random_model i%0d: dut=%h model=%h", i, dutVec(), modelVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_hold();
        test_write_err();
        test_clear();
`ifdef SEL_SKIP_EMPTY_EN
        test_skip();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
